// File: rtl/sys_pkg.sv
// Shared types and defaults for the output-stationary systolic MAC array.
package sys_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_N      = 4;
    localparam int DEF_ACC_W  = 40;
    localparam int DEF_KLEN_W = 8;

    // Bit offset of a lane inside a flattened multi-lane bus.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/sys_pe.sv
// One processing element: registered east/south pass-through plus a signed accumulator.
module sys_pe
    import sys_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              run,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_vld_in,
    input  logic [DATA_W-1:0] w_in,
    input  logic              w_vld_in,
    output logic [DATA_W-1:0] a_out,
    output logic              a_vld_out,
    output logic [DATA_W-1:0] w_out,
    output logic              w_vld_out,
    output logic [ACC_W-1:0]  acc,
    output logic              mac,
    output logic              err
);

    logic [DATA_W-1:0]          a_r;
    logic                       a_vld_r;
    logic [DATA_W-1:0]          w_r;
    logic                       w_vld_r;
    logic [ACC_W-1:0]           acc_r;
    logic signed [2*DATA_W-1:0] prod_s;
    logic signed [ACC_W-1:0]    prod_ext_s;

    assign mac        = run & a_vld_in & w_vld_in;
    assign err        = run & (a_vld_in ^ w_vld_in);
    assign prod_s     = $signed(a_in) * $signed(w_in);
    assign prod_ext_s = ACC_W'(prod_s);

    // Operand pass-through and accumulation (wraps modulo 2^ACC_W).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= {DATA_W{1'b0}};
            a_vld_r <= 1'b0;
            w_r     <= {DATA_W{1'b0}};
            w_vld_r <= 1'b0;
            acc_r   <= {ACC_W{1'b0}};
        end else if (clr) begin
            a_r     <= {DATA_W{1'b0}};
            a_vld_r <= 1'b0;
            w_r     <= {DATA_W{1'b0}};
            w_vld_r <= 1'b0;
            acc_r   <= {ACC_W{1'b0}};
        end else begin
            a_r     <= a_in;
            a_vld_r <= a_vld_in;
            w_r     <= w_in;
            w_vld_r <= w_vld_in;
            if (mac) begin
                acc_r <= acc_r + prod_ext_s;
            end else begin
                acc_r <= acc_r;
            end
        end
    end

    assign a_out     = a_r;
    assign a_vld_out = a_vld_r;
    assign w_out     = w_r;
    assign w_vld_out = w_vld_r;
    assign acc       = acc_r;

endmodule

// File: rtl/sys_array_os.sv
// N x N output-stationary systolic MAC array with tile FSM and row-by-row result drain.
module sys_array_os
    import sys_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N      = DEF_N,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int KLEN_W = DEF_KLEN_W,
    localparam int ROW_W = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [KLEN_W-1:0]   k_len,
    input  logic [N*DATA_W-1:0] data_in,
    input  logic [N-1:0]        data_vld,
    input  logic [N*DATA_W-1:0] weight_in,
    input  logic [N-1:0]        weight_vld,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ROW_W-1:0]    out_row,
    output logic [N*ACC_W-1:0]  out_data,
    output logic                done,
    output logic                skew_err
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N - 1);

    state_t              state_r, state_nx_s;
    logic [KLEN_W-1:0]   k_len_r, mac_cnt_r;
    logic                start_acc_s, run_s, accept_s, err_any_s;
    logic                busy_r, out_valid_r, done_r, skew_err_r;
    logic [ROW_W-1:0]    out_row_r;
    logic [N*ACC_W-1:0]  out_data_r;
    logic                busy_nx_s, out_valid_nx_s, done_nx_s, skew_err_nx_s;
    logic [ROW_W-1:0]    row_nx_s;
    logic [N*ACC_W-1:0]  out_data_nx_s;

    logic [DATA_W-1:0]   a_bus_s     [N][N+1];
    logic                a_vld_bus_s [N][N+1];
    logic [DATA_W-1:0]   w_bus_s     [N+1][N];
    logic                w_vld_bus_s [N+1][N];
    logic [ACC_W-1:0]    acc_s       [N][N];
    logic                mac_s       [N][N];
    logic                err_s       [N][N];

    assign start_acc_s = (state_r == ST_IDLE) && start;
    assign run_s       = (state_r == ST_RUN);
    assign accept_s    = (state_r == ST_DRAIN) && out_valid_r && out_ready;

    // Edge lanes are forced to zero outside RUN so stray upstream valids never reach a PE.
    for (genvar e = 0; e < N; e++) begin : g_edge
        localparam int LSB = lane_lsb(e, DATA_W);
        assign a_bus_s[e][0]     = run_s ? data_in[LSB +: DATA_W] : {DATA_W{1'b0}};
        assign a_vld_bus_s[e][0] = run_s & data_vld[e];
        assign w_bus_s[0][e]     = run_s ? weight_in[LSB +: DATA_W] : {DATA_W{1'b0}};
        assign w_vld_bus_s[0][e] = run_s & weight_vld[e];
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            sys_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
                .clk       (clk),
                .rst_n     (rst_n),
                .clr       (start_acc_s),
                .run       (run_s),
                .a_in      (a_bus_s[i][j]),
                .a_vld_in  (a_vld_bus_s[i][j]),
                .w_in      (w_bus_s[i][j]),
                .w_vld_in  (w_vld_bus_s[i][j]),
                .a_out     (a_bus_s[i][j+1]),
                .a_vld_out (a_vld_bus_s[i][j+1]),
                .w_out     (w_bus_s[i+1][j]),
                .w_vld_out (w_vld_bus_s[i+1][j]),
                .acc       (acc_s[i][j]),
                .mac       (mac_s[i][j]),
                .err       (err_s[i][j])
            );
        end
    end

    // OR-reduce of per-PE valid mismatches.
    always_comb begin
        err_any_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                err_any_s = err_any_s | err_s[i][j];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic; RUN ends once the far-corner PE has done k_len MACs.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s = (k_len == {KLEN_W{1'b0}}) ? ST_DRAIN : ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (mac_cnt_r == k_len_r) begin
                    state_nx_s = ST_DRAIN;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (accept_s && (out_row_r == LAST_ROW)) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, including the drain row mux.
    always_comb begin
        busy_nx_s      = (state_nx_s != ST_IDLE);
        out_valid_nx_s = (state_nx_s == ST_DRAIN);
        done_nx_s      = accept_s && (out_row_r == LAST_ROW);
        if (state_r != ST_DRAIN) begin
            row_nx_s = {ROW_W{1'b0}};
        end else if (accept_s && (out_row_r != LAST_ROW)) begin
            row_nx_s = out_row_r + ROW_W'(1);
        end else if (accept_s) begin
            row_nx_s = {ROW_W{1'b0}};
        end else begin
            row_nx_s = out_row_r;
        end
        // Leaving IDLE the accumulators are being cleared this edge, so present zeros directly.
        out_data_nx_s = {N*ACC_W{1'b0}};
        if (out_valid_nx_s && (state_r != ST_IDLE)) begin
            for (int j = 0; j < N; j++) begin
                out_data_nx_s[j*ACC_W +: ACC_W] = acc_s[row_nx_s][j];
            end
        end else begin
            out_data_nx_s = {N*ACC_W{1'b0}};
        end
        if (start_acc_s) begin
            skew_err_nx_s = 1'b0;
        end else if (run_s) begin
            skew_err_nx_s = skew_err_r | err_any_s;
        end else begin
            skew_err_nx_s = skew_err_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_row_r   <= {ROW_W{1'b0}};
            out_data_r  <= {N*ACC_W{1'b0}};
            done_r      <= 1'b0;
            skew_err_r  <= 1'b0;
        end else begin
            busy_r      <= busy_nx_s;
            out_valid_r <= out_valid_nx_s;
            out_row_r   <= row_nx_s;
            out_data_r  <= out_data_nx_s;
            done_r      <= done_nx_s;
            skew_err_r  <= skew_err_nx_s;
        end
    end

    // Tile length latch and MAC counter at PE(N-1,N-1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_len_r   <= {KLEN_W{1'b0}};
            mac_cnt_r <= {KLEN_W{1'b0}};
        end else if (start_acc_s) begin
            k_len_r   <= k_len;
            mac_cnt_r <= {KLEN_W{1'b0}};
        end else if (run_s && mac_s[N-1][N-1]) begin
            k_len_r   <= k_len_r;
            mac_cnt_r <= mac_cnt_r + KLEN_W'(1);
        end else begin
            k_len_r   <= k_len_r;
            mac_cnt_r <= mac_cnt_r;
        end
    end

    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign out_row   = out_row_r;
    assign out_data  = out_data_r;
    assign done      = done_r;
    assign skew_err  = skew_err_r;

endmodule

// File: tb/tb_sys_array_os.sv
// Scoreboard bench for sys_array_os: directed tiles with hand-computed result rows.
module tb_sys_array_os;

    localparam int DW = 16;
    localparam int N  = 4;
    localparam int AW = 40;
    localparam int KW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [KW-1:0]   k_len = '0;
    logic [N*DW-1:0] data_in = '0;
    logic [N-1:0]    data_vld = '0;
    logic [N*DW-1:0] weight_in = '0;
    logic [N-1:0]    weight_vld = '0;
    logic            busy, out_valid, done, skew_err;
    logic            out_ready = 1'b1;
    logic [1:0]      out_row;
    logic [N*AW-1:0] out_data;

    sys_array_os #(.DATA_W(DW), .N(N), .ACC_W(AW), .KLEN_W(KW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
        .data_in(data_in), .data_vld(data_vld),
        .weight_in(weight_in), .weight_vld(weight_vld),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_data(out_data), .done(done), .skew_err(skew_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              row;
        logic [N*AW-1:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          a_m[N][16];
    int          w_m[N][16];
    logic [AW-1:0] exp_m[N][N];
    int          n_vec = 0, n_miss = 0;
    int          cyc = 0, done_cnt = 0, first_vld_cyc = -1, done_cyc = -1;
    int          t0;

    task automatic chk(input string name, input logic [N*AW-1:0] act, input logic [N*AW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pops the scoreboard on every accepted row and checks hold stability under stall.
    initial begin
        logic            stall, prev_vld;
        logic [1:0]      held_row;
        logic [N*AW-1:0] held_data;
        exp_t            e;
        stall = 1'b0; prev_vld = 1'b0; held_row = '0; held_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
                prev_vld = 1'b0;
            end else begin
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (out_valid && !prev_vld) first_vld_cyc = cyc;
                if (out_valid && stall) begin
                    chk("hold_row", {158'd0, out_row}, {158'd0, held_row});
                    chk("hold_data", out_data, held_data);
                end
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL unexpected_row: got row %0d with no expected entry", out_row);
                    end else begin
                        e = sb_q.pop_front();
                        chk("row_idx", {158'd0, out_row}, e.row[N*AW-1:0]);
                        chk("row_data", out_data, e.data);
                    end
                end
                stall = out_valid && !out_ready;
                held_row = out_row;
                held_data = out_data;
                prev_vld = out_valid;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic fill_const(input int av, input int wv);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 16; k++) begin
                a_m[i][k] = av;
                w_m[i][k] = wv;
            end
    endtask

    task automatic set_exp_const(input logic [AW-1:0] v);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) exp_m[i][j] = v;
    endtask

    // Reference dot products for pattern data.
    task automatic calc_exp(input int k);
        longint s;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int kk = 0; kk < k; kk++) s += longint'(a_m[i][kk]) * longint'(w_m[j][kk]);
                exp_m[i][j] = s[AW-1:0];
            end
    endtask

    // Start a tile and feed skewed lanes; abort_c >= 0 pulls reset at that run cycle instead.
    task automatic feed_tile(input int k, input bit glitch, input int drop_lane, input int drop_k,
                             input int abort_c);
        exp_t e;
        int   kk, v;
        if (abort_c < 0) begin
            for (int r = 0; r < N; r++) begin
                e.row = r;
                for (int j = 0; j < N; j++) e.data[j*AW +: AW] = exp_m[r][j];
                sb_q.push_back(e);
            end
        end
        @(posedge clk); #1;
        start = 1'b1;
        k_len = KW'(k);
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
        for (int c = 0; c < k + N - 1; c++) begin
            if (c == abort_c) begin
                rst_n = 1'b0;
                break;
            end
            for (int i = 0; i < N; i++) begin
                kk = c - i;
                if (kk >= 0 && kk < k) begin
                    v = a_m[i][kk];
                    data_in[i*DW +: DW] = v[DW-1:0];
                    data_vld[i] = !(i == drop_lane && kk == drop_k);
                    v = w_m[i][kk];
                    weight_in[i*DW +: DW] = v[DW-1:0];
                    weight_vld[i] = 1'b1;
                end else begin
                    data_in[i*DW +: DW] = '0;
                    data_vld[i] = 1'b0;
                    weight_in[i*DW +: DW] = '0;
                    weight_vld[i] = 1'b0;
                end
            end
            start = glitch && (c == 2);
            @(posedge clk); #1;
        end
        start = 1'b0;
        data_in = '0; data_vld = '0; weight_in = '0; weight_vld = '0;
    endtask

    task automatic wait_done(input string name);
        int d0, b;
        d0 = done_cnt;
        b = 0;
        while (done_cnt == d0 && b < 200) begin
            @(posedge clk);
            b++;
        end
        if (done_cnt == d0) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, b);
        end
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_done_pulses"}, N*AW'(done_cnt - d0), N*AW'(1));
        chk({name, "_sb_drained"}, N*AW'(sb_q.size()), N*AW'(0));
    endtask

    initial begin
        int pat[10];
        int b, d0;
        pat = '{1, 0, 0, 0, 0, 0, 1, 1, 0, 1};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", {159'd0, busy}, '0);
        chk("rst_out_valid", {159'd0, out_valid}, '0);
        chk("rst_out_row", {158'd0, out_row}, '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_done", {159'd0, done}, '0);
        chk("rst_skew_err", {159'd0, skew_err}, '0);

        // All-ones, k_len=8: every accumulator = 8, valid at t0+15, done at t0+19.
        fill_const(1, 1);
        set_exp_const(40'd8);
        feed_tile(8, 1'b0, -1, -1, -1);
        wait_done("ones");
        chk("ones_first_valid", N*AW'(first_vld_cyc - t0), N*AW'(15));
        chk("ones_done_time", N*AW'(done_cyc - t0), N*AW'(19));
        chk("ones_skew_err", {159'd0, skew_err}, '0);

        // Identity weights: row i column j = i*4+j+1.
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                a_m[i][k] = i * 4 + k + 1;
                w_m[i][k] = (i == k) ? 1 : 0;
            end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) exp_m[i][j] = AW'(i * 4 + j + 1);
        feed_tile(4, 1'b0, -1, -1, -1);
        wait_done("ident");

        // Most-negative operands: 2 * 2^30.
        fill_const(-32768, -32768);
        set_exp_const(40'h0080000000);
        feed_tile(2, 1'b0, -1, -1, -1);
        wait_done("minneg");

        // a=-1, w=3 twice: -6.
        fill_const(-1, 3);
        set_exp_const(40'hFFFFFFFFFA);
        feed_tile(2, 1'b0, -1, -1, -1);
        wait_done("neg6");

        // k_len=0: zero rows straight away.
        set_exp_const(40'd0);
        feed_tile(0, 1'b0, -1, -1, -1);
        wait_done("klen0");
        chk("klen0_first_valid", N*AW'(first_vld_cyc - t0), N*AW'(0));
        chk("klen0_done_time", N*AW'(done_cyc - t0), N*AW'(4));

        // start re-pulsed during RUN has no effect.
        fill_const(1, 1);
        set_exp_const(40'd3);
        feed_tile(3, 1'b1, -1, -1, -1);
        wait_done("glitch");

        // Lane 2 valid dropped for operand k=1: row 2 loses one MAC per column, skew_err sticks.
        fill_const(1, 1);
        set_exp_const(40'd4);
        for (int j = 0; j < N; j++) exp_m[2][j] = 40'd3;
        feed_tile(4, 1'b0, 2, 1, -1);
        wait_done("drop");
        chk("drop_skew_err", {159'd0, skew_err}, {159'd0, 1'b1});
        repeat (5) @(posedge clk);
        #1;
        chk("drop_skew_sticky", {159'd0, skew_err}, {159'd0, 1'b1});

        // Backpressure on mixed-sign pattern data; row 1 stalled 5 cycles.
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 5; k++) begin
                a_m[i][k] = i * 7 - k * 5 + 3;
                w_m[i][k] = i * 3 + k * k - 4;
            end
        calc_exp(5);
        out_ready = 1'b0;
        feed_tile(5, 1'b0, -1, -1, -1);
        b = 0;
        while (!out_valid && b < 100) begin
            @(posedge clk); #1;
            b++;
        end
        for (int p = 0; p < 10; p++) begin
            out_ready = pat[p][0];
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_done("bp");
        chk("bp_skew_cleared", {159'd0, skew_err}, '0);

        // Reset pulled at t0+5 of a k_len=8 tile: outputs cleared, no done.
        fill_const(1, 1);
        d0 = done_cnt;
        feed_tile(8, 1'b0, -1, -1, 5);
        @(negedge clk);
        chk("mid_rst_busy", {159'd0, busy}, '0);
        chk("mid_rst_out_valid", {159'd0, out_valid}, '0);
        chk("mid_rst_out_data", out_data, '0);
        chk("mid_rst_done", {159'd0, done}, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("mid_rst_no_done", N*AW'(done_cnt - d0), '0);
        chk("mid_rst_idle", {159'd0, busy}, '0);

        // Normal tile after the aborted one.
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                a_m[i][k] = i * 4 + k + 1;
                w_m[i][k] = (i == k) ? 1 : 0;
            end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) exp_m[i][j] = AW'(i * 4 + j + 1);
        feed_tile(4, 1'b0, -1, -1, -1);
        wait_done("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
